irq_gen: RTL and testbench

Parametrised multi-channel periodic interrupt generator for exercising and characterising the PS interrupt controller (GIC) from PL. Each channel has its own run-time period, pulse length, enable and mode. Pulse mode gives a self-clearing pulse train. Level mode holds the line until software acknowledges it, and flags missed acknowledges as overruns. Per-channel lines connect to PL-to-PS IRQ inputs; `irq_any` serves single-input fabrics.

---
 rtl/irq_gen_pkg.sv | 13 +
 rtl/irq_gen_ch.sv | 87 ++++++++
 rtl/irq_gen.sv | 51 +++++
 tb/tb_irq_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_gen_pkg.sv
// irq_gen_pkg: shared types and constants for the periodic interrupt generator.
//   irq_mode_t        - per-channel output mode (pulse train or acknowledged level)
//   IRQ_GEN_CNT_W_DEF - default width of counter, period and pulse length
package irq_gen_pkg;

  typedef enum logic {
    IRQ_PULSE = 1'b0,
    IRQ_LEVEL = 1'b1
  } irq_mode_t;

  localparam int IRQ_GEN_CNT_W_DEF = 32;

endpackage

// File: rtl/irq_gen_ch.sv
// irq_gen_ch: one interrupt channel (counter, pending, sticky overrun, irq register).
// Ports:
//   i_clk, i_resetn     - clock, synchronous active-low reset
//   i_ch_en             - channel enable; low forces counter/pending/irq to 0
//   i_mode              - 0 = pulse train, 1 = level held until acknowledged
//   i_period            - terminal count; interval is period+1 cycles
//   i_pulse_len         - pulse width in cycles (pulse mode)
//   i_ack               - level-mode acknowledge strobe
//   i_clr_overrun       - clears the sticky overrun flag
//   o_irq               - registered interrupt line
//   o_overrun           - sticky missed-acknowledge flag
module irq_gen_ch
  import irq_gen_pkg::*;
#(
  parameter int CNT_W = IRQ_GEN_CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_ch_en,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_pulse_len,
  input  logic             i_ack,
  input  logic             i_clr_overrun,
  output logic             o_irq,
  output logic             o_overrun
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_irq;
  logic             r_ovr;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_irq_nxt;
  logic             w_ovr_set;
  logic             w_event;
  irq_mode_t        w_mode;

  assign w_mode = irq_mode_t'(i_mode);

  always_comb begin
    w_cnt_nxt  = '0;
    w_pend_nxt = 1'b0;
    w_irq_nxt  = 1'b0;
    w_ovr_set  = 1'b0;
    // An event is the first enabled cycle and every wrap after it.
    w_event    = i_ch_en && (r_cnt == '0);

    if (i_ch_en) begin
      // >= so a period lowered below the current count wraps immediately.
      w_cnt_nxt = (r_cnt >= i_period) ? '0 : r_cnt + 1'b1;

      if (w_mode == IRQ_LEVEL) begin
        // Event wins over ack, so a coinciding ack never loses an interrupt.
        if (w_event)    w_pend_nxt = 1'b1;
        else if (i_ack) w_pend_nxt = 1'b0;
        else            w_pend_nxt = r_pend;
        w_ovr_set = w_event && r_pend && !i_ack;
        w_irq_nxt = w_pend_nxt;
      end else begin
        // Pending is held at 0 in pulse mode, so leaving level mode clears it.
        w_irq_nxt = (r_cnt < i_pulse_len);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_irq  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_pend_nxt;
      r_irq  <= w_irq_nxt;
      // Set has priority over a simultaneous clear.
      r_ovr  <= w_ovr_set || (r_ovr && !i_clr_overrun);
    end
  end

  assign o_irq     = r_irq;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/irq_gen.sv
// irq_gen: multi-channel periodic interrupt generator for exercising the GIC from PL.
// Ports:
//   clk, resetn   - clock, synchronous active-low reset
//   ch_en, mode   - per-channel enable and mode (0 pulse, 1 level)
//   period        - per-channel terminal count, channel c at [c*CNT_W +: CNT_W]
//   pulse_len     - per-channel pulse width, same packing as period
//   ack           - per-channel level-mode acknowledge strobe
//   clr_overrun   - per-channel sticky overrun clear
//   irq           - per-channel registered interrupt lines
//   irq_any       - OR of irq, for single-input fabrics
//   overrun       - per-channel sticky missed-acknowledge flags
module irq_gen
  import irq_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = IRQ_GEN_CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] pulse_len,
  input  logic [NUM_CH-1:0]       ack,
  input  logic [NUM_CH-1:0]       clr_overrun,
  output logic [NUM_CH-1:0]       irq,
  output logic                    irq_any,
  output logic [NUM_CH-1:0]       overrun
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    irq_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk         (clk),
      .i_resetn      (resetn),
      .i_ch_en       (ch_en[c]),
      .i_mode        (mode[c]),
      .i_period      (period[c*CNT_W +: CNT_W]),
      .i_pulse_len   (pulse_len[c*CNT_W +: CNT_W]),
      .i_ack         (ack[c]),
      .i_clr_overrun (clr_overrun[c]),
      .o_irq         (irq[c]),
      .o_overrun     (overrun[c])
    );
  end

  // Combinational OR of registered lines: no added latency.
  assign irq_any = |irq;

endmodule

// File: tb/tb_irq_gen.sv
// tb_irq_gen: directed-vector bench for irq_gen with a per-cycle expected queue.
module tb_irq_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int W      = 10;  // {check, irq[3:0], overrun[3:0], irq_any}

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH*CNT_W-1:0] pulse_len;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       clr_overrun;
  logic [NUM_CH-1:0]       irq;
  logic                    irq_any;
  logic [NUM_CH-1:0]       overrun;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  string        scen;
  int           checks = 0;
  int           errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  irq_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ch_en      (ch_en),
    .mode       (mode),
    .period     (period),
    .pulse_len  (pulse_len),
    .ack        (ack),
    .clr_overrun(clr_overrun),
    .irq        (irq),
    .irq_any    (irq_any),
    .overrun    (overrun)
  );

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input bit chk, input logic [3:0] ei, input logic [3:0] eo);
    exp_q.push_back({chk, ei, eo, |ei});
    name_q.push_back(scen);
  endtask

  task automatic set_cfg(input int ch, input int per, input int len);
    period[ch*CNT_W +: CNT_W]    = CNT_W'(per);
    pulse_len[ch*CNT_W +: CNT_W] = CNT_W'(len);
  endtask

  // Disable everything and clear overruns; outputs must be all zero one cycle later.
  task automatic idle();
    ch_en       = '0;
    ack         = '0;
    mode        = '0;
    clr_overrun = '1;
    expect_cyc(1'b0, '0, '0);
    tick();
    clr_overrun = '0;
    expect_cyc(1'b1, '0, '0);
    tick();
  endtask

  // ch0 pulse train, period 9: high for min(len,10) cycles per 10, starting cycle 1.
  task automatic run_pulse(input int len, input string nm);
    scen = nm;
    set_cfg(0, 9, len);
    mode  = '0;
    ch_en = 4'b0001;
    for (int t = 0; t <= 30; t++) begin
      logic [3:0] e;
      e    = '0;
      e[0] = (t >= 1) && (((t - 1) % 10) < len);
      expect_cyc(1'b1, e, '0);
      tick();
    end
    idle();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e[9]) begin
        checks++;
        if ({irq, overrun, irq_any} !== e[8:0]) begin
          errors++;
          $display("FAIL %s @%0t: irq=%b overrun=%b irq_any=%b, expected irq=%b overrun=%b irq_any=%b",
                   n, $time, irq, overrun, irq_any, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn      = 1'b0;
    ch_en       = '0;
    mode        = '0;
    ack         = '0;
    clr_overrun = '0;
    period      = '0;
    pulse_len   = '0;

    scen = "reset_initial";
    tick();
    expect_cyc(1'b1, '0, '0);
    tick();
    resetn = 1'b1;
    expect_cyc(1'b1, '0, '0);
    tick();

    run_pulse(2,  "pulse_len2");
    run_pulse(0,  "pulse_len0");
    run_pulse(15, "pulse_len15");

    // Level mode with one ack at cycle 5; next event at cycle 20.
    scen = "level_ack";
    set_cfg(1, 19, 0);
    mode  = 4'b0010;
    ch_en = 4'b0010;
    for (int t = 0; t <= 30; t++) begin
      logic [3:0] e;
      ack  = (t == 5) ? 4'b0010 : 4'b0000;
      e    = '0;
      e[1] = (t >= 1 && t <= 5) || (t >= 21);
      expect_cyc(1'b1, e, '0);
      tick();
    end
    ack = '0;
    idle();

    // Level mode, events at 0,20,40,60,80. Missed ack at 20 -> overrun at 21.
    // Clear alone at 30. Ack coincident with event at 40 -> no overrun.
    // Missed at 60 -> overrun at 61. Clear plus event at 80 -> set wins.
    // Reset held 85..87, released at 88 with channel still enabled.
    scen = "overrun_reset";
    set_cfg(1, 19, 0);
    mode  = 4'b0010;
    ch_en = 4'b0010;
    for (int t = 0; t <= 95; t++) begin
      logic [3:0] ei;
      logic [3:0] eo;
      ack         = (t == 40) ? 4'b0010 : 4'b0000;
      clr_overrun = (t == 30 || t == 80) ? 4'b0010 : 4'b0000;
      resetn      = !(t >= 85 && t <= 87);
      ei    = '0;
      eo    = '0;
      ei[1] = (t >= 1 && t <= 85) || (t >= 89);
      eo[1] = (t >= 21 && t <= 30) || (t >= 61 && t <= 85);
      expect_cyc(1'b1, ei, eo);
      tick();
    end
    ack         = '0;
    clr_overrun = '0;
    resetn      = 1'b1;
    idle();

    // Period lowered from 99 to 10 while cnt=50: events at 51, 62, 73.
    scen = "period_shrink";
    set_cfg(0, 99, 1);
    mode  = '0;
    ch_en = 4'b0001;
    for (int t = 0; t <= 80; t++) begin
      logic [3:0] e;
      if (t == 50) set_cfg(0, 10, 1);
      e    = '0;
      e[0] = (t == 1) || (t == 52) || (t == 63) || (t == 74);
      expect_cyc(1'b1, e, '0);
      tick();
    end
    idle();

    // Four pulse channels, intervals 4/6/8/12; ch2 disabled at cycle 18 mid-pulse.
    scen = "multi";
    set_cfg(0, 3, 1);
    set_cfg(1, 5, 2);
    set_cfg(2, 7, 3);
    set_cfg(3, 11, 4);
    mode  = '0;
    ch_en = 4'b1111;
    for (int t = 0; t <= 40; t++) begin
      logic [3:0] e;
      if (t == 18) ch_en = 4'b1011;
      e    = '0;
      e[0] = (t >= 1) && (((t - 1) % 4) < 1);
      e[1] = (t >= 1) && (((t - 1) % 6) < 2);
      e[2] = (t >= 1) && (t <= 18) && (((t - 1) % 8) < 3);
      e[3] = (t >= 1) && (((t - 1) % 12) < 4);
      expect_cyc(1'b1, e, '0);
      tick();
    end
    idle();

    // ---------------- final report ----------------
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
